// File: rtl/switch_pio_irq_pkg.sv
// Shared constants for the switch PIO: register addresses and edge-mode encodings.
package switch_pio_irq_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/switch_debounce.sv
// One switch bit: two-flop synchroniser followed by a saturating debounce counter.
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    output logic stable
);

    logic sync1;
    logic sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= in_bit;
            sync2 <= sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_nodb
            assign stable = sync2;
        end else begin : g_db
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
            localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

            logic [CW-1:0] cnt;
            logic          stable_q;

            // The count tracks how long sync2 has disagreed with the accepted level;
            // agreement at any point throws the partial count away.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt      <= '0;
                    stable_q <= 1'b0;
                end else if (sync2 == stable_q) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    stable_q <= sync2;
                    cnt      <= '0;
                end else if (cnt != CNT_MAX) begin
                    cnt <= cnt + CW'(1);
                end
            end

            assign stable = stable_q;
        end
    endgenerate

endmodule

// File: rtl/switch_pio_irq.sv
// Avalon-MM switch input port with per-bit debounce, edge capture and level interrupt.
module switch_pio_irq
    import switch_pio_irq_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_MODE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] wdata;
    logic [31:0]      rd_next;
    logic             wr_en;
    logic             unused_wdata;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            switch_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_db (
                .clk    (clk),
                .reset_n(reset_n),
                .in_bit (in_port[i]),
                .stable (stable[i])
            );
        end
    endgenerate

    assign wr_en        = chipselect & ~write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    always_comb begin
        edge_hit = '0;
        case (EDGE_MODE)
            EDGE_RISE: edge_hit = stable & ~stable_d;
            EDGE_FALL: edge_hit = ~stable & stable_d;
            EDGE_ANY:  edge_hit = stable ^ stable_d;
            default:   edge_hit = '0;
        endcase
    end

    // A new edge is ORed in after the clear mask, so set beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d <= '0;
            irqmask  <= '0;
            edgecap  <= '0;
        end else begin
            stable_d <= stable;
            if (wr_en && address == ADDR_IRQMASK) begin
                irqmask <= wdata;
            end
            if (wr_en && address == ADDR_EDGECAP) begin
                edgecap <= (edgecap & ~wdata) | edge_hit;
            end else begin
                edgecap <= edgecap | edge_hit;
            end
        end
    end

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:    rd_next[WIDTH-1:0] = stable;
            ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecap;
            default:      rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

    assign irq = |(edgecap & irqmask);

endmodule
